// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory stage and the data-memory responder.
// A request transfers on a rising edge where req_valid && req_ready; rsp_valid is a
// one-cycle pulse that is never stalled, so the requester must take it that cycle.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// RV32I data-memory responder: one request at a time, WAIT_CYCLES wait states,
// byte/half/word stores, sign/zero-extended loads, error flag on bad accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus,
  output logic [1:0]       dbgState
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} stateT;

  stateT         stateQ, stateD;
  logic [CW-1:0] cntQ, cntD;
  logic          accept, commit;

  logic          weQ;
  logic [2:0]    funct3Q;
  logic [31:0]   addrQ, wdataQ;
  logic [31:0]   rdataQ;
  logic          errQ;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          legalF3, misaligned, outOfRange, err;
  logic [AW-1:0] wordIdx;
  logic [31:0]   rdWord, loadData, wrData;
  logic [7:0]    byteVal;
  logic [15:0]   halfVal;
  logic [3:0]    wrMask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= IDLE;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  always_comb begin
    stateD        = stateQ;
    cntD          = cntQ;
    accept        = 1'b0;
    commit        = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (stateQ)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept = 1'b1;
          cntD   = CW'(WAIT_CYCLES);
          stateD = WAIT;
        end
      end
      WAIT: begin
        if (cntQ == '0) begin
          commit = 1'b1;
          stateD = RESP;
        end else begin
          cntD = cntQ - CW'(1);
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        stateD        = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  // Error decode works only on the registered request, so late input changes are harmless.
  always_comb begin
    if (weQ) legalF3 = funct3Q inside {3'b000, 3'b001, 3'b010};
    else     legalF3 = funct3Q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misaligned = ((funct3Q[1:0] == 2'b01) && addrQ[0]) ||
                 ((funct3Q[1:0] == 2'b10) && (addrQ[1:0] != 2'b00));
    outOfRange = {2'b00, addrQ[31:2]} >= 32'(DEPTH_WORDS);
    err        = !legalF3 || misaligned || outOfRange;
  end

  assign wordIdx = addrQ[AW+1:2];
  assign rdWord  = mem[wordIdx];
  assign byteVal = rdWord[{addrQ[1:0], 3'b000} +: 8];
  assign halfVal = addrQ[1] ? rdWord[31:16] : rdWord[15:0];

  always_comb begin
    case (funct3Q[1:0])
      2'b00:   loadData = {{24{!funct3Q[2] & byteVal[7]}}, byteVal};
      2'b01:   loadData = {{16{!funct3Q[2] & halfVal[15]}}, halfVal};
      default: loadData = rdWord;
    endcase
  end

  // Store data is replicated across lanes so the mask alone picks the target bytes.
  always_comb begin
    case (funct3Q[1:0])
      2'b00: begin
        wrMask = 4'b0001 << addrQ[1:0];
        wrData = {4{wdataQ[7:0]}};
      end
      2'b01: begin
        wrMask = addrQ[1] ? 4'b1100 : 4'b0011;
        wrData = {2{wdataQ[15:0]}};
      end
      default: begin
        wrMask = 4'b1111;
        wrData = wdataQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && weQ && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (wrMask[i]) mem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weQ     <= 1'b0;
      funct3Q <= 3'b000;
      addrQ   <= '0;
      wdataQ  <= '0;
      rdataQ  <= '0;
      errQ    <= 1'b0;
    end else begin
      if (accept) begin
        weQ     <= bus.req_we;
        funct3Q <= bus.req_funct3;
        addrQ   <= bus.req_addr;
        wdataQ  <= bus.req_wdata;
      end
      if (commit) begin
        errQ   <= err;
        rdataQ <= (weQ || err) ? 32'h0 : loadData;
      end
    end
  end

  assign bus.rsp_rdata = rdataQ;
  assign bus.rsp_err   = errQ;
  assign dbgState      = stateQ;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/backpressure sequences,
// and randomized traffic checked against a byte-addressed reference memory.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int WAITC = 2;

  logic       clk;
  logic       rst;
  logic [1:0] dbgState;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbgState (dbgState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vecT;

  vecT         vecs[$];
  int          nVec = 0;
  int          nMis = 0;
  logic [7:0]  refMem [256];
  logic [31:0] expQ[$];
  logic        expErrQ[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
    end
  endtask

  function automatic void addVec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRdata, input logic expErr);
    vecT v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.expRdata = expRdata; v.expErr = expErr;
    vecs.push_back(v);
  endfunction

  // Reference: memory as bytes, access size 2**f3[1:0], extension by arithmetic.
  function automatic void refOp(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int     n;
    bit     legal;
    longint v;
    legal = we ? (f3 inside {0, 1, 2}) : (f3 inside {0, 1, 2, 4, 5});
    n     = 1 << f3[1:0];
    err   = !legal || (addr % n != 0) || (addr >= 4 * DEPTH);
    rdata = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) refMem[addr + i] = 8'(wdata >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(refMem[addr + i]) << (8 * i);
      if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      rdata = 32'(v);
    end
  endfunction

  task automatic doReq(input string name, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int n;
    rdata = 32'h0;
    err   = 1'b0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    n = 0;
    while (!bus.req_ready && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      check($sformatf("%s ready-timeout", name), 32'h0, 32'h1);
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    n = 1;
    while (!bus.rsp_valid && n < 40) begin @(negedge clk); n++; end
    check($sformatf("%s latency", name), 32'(n), 32'(WAITC + 2));
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    @(negedge clk);
    check($sformatf("%s pulse-end {rsp_valid,req_ready}", name),
          {30'b0, bus.rsp_valid, bus.req_ready}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, addr, wd;
    logic        er, we, sawRsp;
    logic [2:0]  f3;
    int          n;
    logic [2:0]  loadF3 [5];
    loadF3[0] = 3'b000; loadF3[1] = 3'b001; loadF3[2] = 3'b010; loadF3[3] = 3'b100; loadF3[4] = 3'b101;

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    #1;
    check("reset req_ready", {31'b0, bus.req_ready}, 32'h1);
    check("reset rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset rsp_err", {31'b0, bus.rsp_err}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset req_ready", {31'b0, bus.req_ready}, 32'h1);
    check("post-reset rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);

    // Directed table: store/load lanes, extension, misalignment, illegal funct3, range.
    addVec(1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0);
    addVec(0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0);
    addVec(1, 3'b010, 32'h20,   32'h0,        32'h0,        0);
    addVec(1, 3'b000, 32'h23,   32'h000000F0, 32'h0,        0);
    addVec(0, 3'b010, 32'h20,   32'h0,        32'hF0000000, 0);
    addVec(0, 3'b000, 32'h23,   32'h0,        32'hFFFFFFF0, 0);
    addVec(0, 3'b100, 32'h23,   32'h0,        32'h000000F0, 0);
    addVec(1, 3'b010, 32'h40,   32'h11112222, 32'h0,        0);
    addVec(1, 3'b001, 32'h42,   32'h00008001, 32'h0,        0);
    addVec(0, 3'b010, 32'h40,   32'h0,        32'h80012222, 0);
    addVec(0, 3'b001, 32'h42,   32'h0,        32'hFFFF8001, 0);
    addVec(0, 3'b101, 32'h42,   32'h0,        32'h00008001, 0);
    addVec(0, 3'b001, 32'h41,   32'h0,        32'h0,        1);
    addVec(1, 3'b010, 32'h42,   32'hAAAAAAAA, 32'h0,        1);
    addVec(0, 3'b010, 32'h40,   32'h0,        32'h80012222, 0);
    addVec(0, 3'b011, 32'h40,   32'h0,        32'h0,        1);
    addVec(1, 3'b100, 32'h40,   32'h000000AA, 32'h0,        1);
    addVec(1, 3'b011, 32'h40,   32'h55555555, 32'h0,        1);
    addVec(0, 3'b010, 32'h40,   32'h0,        32'h80012222, 0);
    addVec(0, 3'b010, 32'h1000, 32'h0,        32'h0,        1);
    addVec(1, 3'b010, 32'hFFC,  32'hCAFEF00D, 32'h0,        0);
    addVec(0, 3'b010, 32'hFFC,  32'h0,        32'hCAFEF00D, 0);
    addVec(1, 3'b000, 32'h1003, 32'h00000011, 32'h0,        1);
    addVec(0, 3'b010, 32'hFFC,  32'h0,        32'hCAFEF00D, 0);

    foreach (vecs[i]) begin
      doReq($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er);
      check($sformatf("vec%0d rsp_rdata", i), rd, vecs[i].expRdata);
      check($sformatf("vec%0d rsp_err", i), {31'b0, er}, {31'b0, vecs[i].expErr});
    end

    // Reset during WAIT aborts the store and suppresses the response.
    doReq("abort-prewrite", 1'b1, 3'b010, 32'h80, 32'h55AA55AA, rd, er);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h80; bus.req_wdata = 32'h12345678;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort busy req_ready", {31'b0, bus.req_ready}, 32'h0);
    sawRsp = 1'b0;
    rst = 1'b1;
    repeat (2) begin @(negedge clk); sawRsp |= bus.rsp_valid; end
    rst = 1'b0;
    repeat (6) begin @(negedge clk); sawRsp |= bus.rsp_valid; end
    check("abort no rsp_valid", {31'b0, sawRsp}, 32'h0);
    check("abort req_ready", {31'b0, bus.req_ready}, 32'h1);
    doReq("abort-readback", 1'b0, 3'b010, 32'h80, 32'h0, rd, er);
    check("abort readback rdata", rd, 32'h55AA55AA);
    check("abort readback err", {31'b0, er}, 32'h0);

    // Reset during RESP drops rsp_valid at once; the store has already landed.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h84; bus.req_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 40) begin @(negedge clk); n++; end
    check("resp-reset latency", 32'(n), 32'(WAITC + 2));
    #2 rst = 1'b1;
    #1 check("resp-reset rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    doReq("resp-reset-readback", 1'b0, 3'b010, 32'h84, 32'h0, rd, er);
    check("resp-reset readback", rd, 32'hA5A5A5A5);

    // req_valid held high while busy is ignored, and late input changes are ignored.
    doReq("busy-init", 1'b1, 3'b010, 32'h8C, 32'h0, rd, er);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h88; bus.req_wdata = 32'h00000001;
    @(negedge clk);
    bus.req_addr = 32'h8C; bus.req_wdata = 32'hFFFFFFFF;
    n = 1;
    while (!bus.rsp_valid && n < 40) begin @(negedge clk); n++; end
    check("busy latency", 32'(n), 32'(WAITC + 2));
    check("busy rsp_err", {31'b0, bus.rsp_err}, 32'h0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("busy idle {rsp_valid,req_ready}", {30'b0, bus.rsp_valid, bus.req_ready}, 32'h1);
    doReq("busy-rd88", 1'b0, 3'b010, 32'h88, 32'h0, rd, er);
    check("busy word 0x88", rd, 32'h00000001);
    doReq("busy-rd8c", 1'b0, 3'b010, 32'h8C, 32'h0, rd, er);
    check("busy word 0x8C", rd, 32'h00000000);

    // Randomized traffic over bytes 0..0xFF plus out-of-range addresses.
    for (int w = 0; w < 64; w++) begin
      wd = $urandom;
      refOp(1'b1, 3'b010, 32'(w * 4), wd, rd, er);
      doReq($sformatf("init%0d", w), 1'b1, 3'b010, 32'(w * 4), wd, rd, er);
      check($sformatf("init%0d rsp_err", w), {31'b0, er}, 32'h0);
    end
    for (int k = 0; k < 300; k++) begin
      logic [31:0] eRd;
      logic        eEr;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = loadF3[$urandom_range(0, 4)];
      if ($urandom_range(0, 19) == 0) addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 4095));
      else                            addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << f3[1:0]) - 1);
      wd = $urandom;
      refOp(we, f3, addr, wd, eRd, eEr);
      expQ.push_back(eRd);
      expErrQ.push_back(eEr);
      doReq($sformatf("rnd%0d", k), we, f3, addr, wd, rd, er);
      check($sformatf("rnd%0d rsp_rdata we=%0d f3=%0d addr=0x%08h", k, we, f3, addr), rd, expQ.pop_front());
      check($sformatf("rnd%0d rsp_err", k), {31'b0, er}, {31'b0, expErrQ.pop_front()});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
